// File: rtl/snake_body_tracker.sv
// Snake segment list for the 16x16 grid: steps the head on each game tick, detects
// apple/wall/self collisions and answers registered per-pixel "is snake here" queries.
module snake_body_tracker #(
    parameter int MAX_LEN  = 50,
    parameter int INIT_LEN = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    tick,
    input  logic [1:0]              dir,
    input  logic [7:0]              apple_cord,
    input  logic [3:0]              x,
    input  logic [3:0]              y,
    output logic [MAX_LEN-1:0][7:0] body,
    output logic [5:0]              length,
    output logic                    goodColl,
    output logic                    badColl,
    output logic                    dead,
    output logic                    snake
);

    typedef enum logic [1:0] {IDLE, RUN, DEAD} state_t;
    typedef enum logic [1:0] {UP = 2'b00, DOWN = 2'b01, LEFT = 2'b10, RIGHT = 2'b11} dir_t;

    localparam int unsigned MAX_U  = MAX_LEN;
    localparam int unsigned INIT_U = INIT_LEN;

    state_t                   state, state_n;
    dir_t                     dir_lat, dir_lat_n, dir_app, dir_app_n;
    logic [MAX_LEN-1:0][7:0]  body_n;
    logic [5:0]               length_n, lim;
    logic                     good_n, bad_n, snake_n;
    logic [3:0]               hx, hy, nx, ny;
    logic [7:0]               nh, tail_new;
    logic                     wall, grow, self_hit, extend;

    function automatic dir_t opposite(input dir_t d);
        return dir_t'({d[1], ~d[0]});
    endfunction

    assign dead = (state == DEAD);

    always_comb begin
        state_n   = state;
        dir_lat_n = dir_lat;
        dir_app_n = dir_app;
        body_n    = body;
        length_n  = length;
        good_n    = 1'b0;
        bad_n     = 1'b0;

        hx   = body[0][7:4];
        hy   = body[0][3:0];
        nx   = hx;
        ny   = hy;
        wall = 1'b0;
        case (dir_lat)
            UP:      begin wall = (hy == 4'd0);  ny = hy - 4'd1; end
            DOWN:    begin wall = (hy == 4'd15); ny = hy + 4'd1; end
            LEFT:    begin wall = (hx == 4'd0);  nx = hx - 4'd1; end
            default: begin wall = (hx == 4'd15); nx = hx + 4'd1; end
        endcase
        nh   = {nx, ny};
        grow = (nh == apple_cord);

        // The tail slot only counts as an obstacle when it is not about to vacate.
        lim      = grow ? length : length - 6'd1;
        self_hit = 1'b0;
        for (int unsigned i = 1; i < MAX_U; i++) begin
            if (i < 32'(lim) && body[i] == nh)
                self_hit = 1'b1;
        end

        extend   = grow && (length < 6'(MAX_LEN));
        tail_new = extend ? body[length - 6'd1] : body[length - 6'd2];

        snake_n = 1'b0;
        for (int unsigned i = 0; i < MAX_U; i++) begin
            if (i < 32'(length) && body[i] == {x, y})
                snake_n = 1'b1;
        end

        case (state)
            IDLE: begin
                if (start)
                    state_n = RUN;
            end
            RUN: begin
                if (tick) begin
                    dir_app_n = dir_lat;
                    if (wall || self_hit) begin
                        bad_n   = 1'b1;
                        state_n = DEAD;
                    end else begin
                        good_n    = grow;
                        body_n[0] = nh;
                        for (int unsigned i = 1; i < MAX_U; i++)
                            body_n[i] = (i < 32'(length)) ? body[i-1] : tail_new;
                        if (extend)
                            length_n = length + 6'd1;
                    end
                end
                // Reversal is judged against the direction in force for the next step.
                if (dir_t'(dir) != opposite(dir_app_n))
                    dir_lat_n = dir_t'(dir);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            length   <= 6'(INIT_LEN);
            dir_lat  <= RIGHT;
            dir_app  <= RIGHT;
            goodColl <= 1'b0;
            badColl  <= 1'b0;
            snake    <= 1'b0;
            for (int unsigned i = 0; i < MAX_U; i++)
                body[i] <= (i < INIT_U) ? {4'(7 - i), 4'd7} : {4'(8 - INIT_LEN), 4'd7};
        end else begin
            state    <= state_n;
            length   <= length_n;
            dir_lat  <= dir_lat_n;
            dir_app  <= dir_app_n;
            goodColl <= good_n;
            badColl  <= bad_n;
            snake    <= snake_n;
            body     <= body_n;
        end
    end

endmodule

// File: tb/tb_snake_body_tracker.sv
// Bench for snake_body_tracker: directed scenarios plus random play against a queue-based snake model.
module tb_snake_body_tracker;

    localparam int MAX_LEN  = 50;
    localparam int INIT_LEN = 3;
    localparam int W        = MAX_LEN * 8 + 10;

    logic                    clk = 1'b0;
    logic                    reset, start, tick;
    logic [1:0]              dir;
    logic [7:0]              apple_cord;
    logic [3:0]              x, y;
    logic [MAX_LEN-1:0][7:0] body;
    logic [5:0]              length;
    logic                    goodColl, badColl, dead, snake;

    always #5 clk = ~clk;

    snake_body_tracker #(.MAX_LEN(MAX_LEN), .INIT_LEN(INIT_LEN)) dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick), .dir(dir),
        .apple_cord(apple_cord), .x(x), .y(y), .body(body), .length(length),
        .goodColl(goodColl), .badColl(badColl), .dead(dead), .snake(snake)
    );

    int nvec  = 0;
    int nfail = 0;

    // Model: snake as a list of cells, head first; 0 idle, 1 running, 2 dead.
    logic [7:0] mq[$];
    int         m_state;
    logic [1:0] m_lat, m_app;
    logic       m_good, m_bad, m_snake;

    function automatic logic [1:0] opp(input logic [1:0] d);
        case (d)
            2'd0:    return 2'd1;
            2'd1:    return 2'd0;
            2'd2:    return 2'd3;
            default: return 2'd2;
        endcase
    endfunction

    function automatic logic [7:0] next_cell(input logic [7:0] h, input logic [1:0] d);
        int cx, cy;
        cx = int'(h[7:4]);
        cy = int'(h[3:0]);
        case (d)
            2'd0:    cy = cy - 1;
            2'd1:    cy = cy + 1;
            2'd2:    cx = cx - 1;
            default: cx = cx + 1;
        endcase
        return {4'(cx), 4'(cy)};
    endfunction

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < INIT_LEN; i++) mq.push_back({4'(7 - i), 4'd7});
        m_state = 0;
        m_lat   = 2'd3;
        m_app   = 2'd3;
        m_good  = 1'b0;
        m_bad   = 1'b0;
        m_snake = 1'b0;
    endtask

    task automatic model_step(input logic r, input logic st, input logic tk, input logic [1:0] d,
                              input logic [7:0] ap, input logic [7:0] q);
        logic       hit, grow;
        int         nx, ny;
        logic [7:0] nh;
        hit = 1'b0;
        for (int i = 0; i < mq.size(); i++) if (mq[i] == q) hit = 1'b1;
        m_good = 1'b0;
        m_bad  = 1'b0;
        if (r) begin
            model_reset();
            return;
        end
        m_snake = hit;
        if (m_state == 0) begin
            if (st) m_state = 1;
        end else if (m_state == 1) begin
            if (tk) begin
                nx = int'(mq[0][7:4]);
                ny = int'(mq[0][3:0]);
                case (m_lat)
                    2'd0:    ny--;
                    2'd1:    ny++;
                    2'd2:    nx--;
                    default: nx++;
                endcase
                if (nx < 0 || nx > 15 || ny < 0 || ny > 15) begin
                    m_bad   = 1'b1;
                    m_state = 2;
                end else begin
                    nh   = {4'(nx), 4'(ny)};
                    grow = (nh == ap);
                    hit  = 1'b0;
                    for (int i = 1; i < mq.size() - (grow ? 0 : 1); i++) if (mq[i] == nh) hit = 1'b1;
                    if (hit) begin
                        m_bad   = 1'b1;
                        m_state = 2;
                    end else begin
                        mq.push_front(nh);
                        if (!grow || mq.size() > MAX_LEN) void'(mq.pop_back());
                        m_good = grow;
                    end
                end
                m_app = m_lat;
            end
            if (d != opp(m_app)) m_lat = d;
        end
    endtask

    function automatic logic [W-1:0] exp_all();
        logic [MAX_LEN-1:0][7:0] b;
        for (int i = 0; i < MAX_LEN; i++) b[i] = (i < mq.size()) ? mq[i] : mq[mq.size() - 1];
        return {b, 6'(mq.size()), m_good, m_bad, (m_state == 2), m_snake};
    endfunction

    task automatic cyc(input logic r, input logic st, input logic tk, input logic [1:0] d,
                       input logic [7:0] ap, input logic [7:0] q);
        reset = r; start = st; tick = tk; dir = d; apple_cord = ap; {x, y} = q;
        model_step(r, st, tk, d, ap, q);
        @(posedge clk);
        #1;
    endtask

    task automatic move(input logic [1:0] d, input logic [7:0] ap);
        cyc(1'b0, 1'b0, 1'b0, d, ap, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, d, ap, 8'h00);
    endtask

    task automatic test_reset();
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        nvec++;
        if ({body, length, goodColl, badColl, dead, snake} !== exp_all()) begin
            nfail++; $display("FAIL reset_all: got %h want %h", {body, length, goodColl, badColl, dead, snake}, exp_all());
        end
        nvec++;
        if ({body[0], body[1], body[2], body[49], length} !== {8'h77, 8'h67, 8'h57, 8'h57, 6'd3}) begin
            nfail++; $display("FAIL reset_const: got %h %h %h %h len %0d want 77 67 57 57 len 3",
                              body[0], body[1], body[2], body[49], length);
        end
    endtask

    task automatic test_start_move();
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b1, 2'd3, 8'h00, 8'h00);
        nvec++;
        if (body[0] !== 8'h77) begin
            nfail++; $display("FAIL start_tick_nomove: got %h want 77", body[0]);
        end
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00);
        nvec++;
        if ({body[0], body[1], body[2], body[3], body[49], length, goodColl, badColl} !==
            {8'h87, 8'h77, 8'h67, 8'h67, 8'h67, 6'd3, 1'b0, 1'b0}) begin
            nfail++; $display("FAIL first_step: got %h %h %h %h %h len %0d g%b b%b want 87 77 67 67 67 len 3 g0 b0",
                              body[0], body[1], body[2], body[3], body[49], length, goodColl, badColl);
        end
        nvec++;
        if ({body, length, goodColl, badColl, dead, snake} !== exp_all()) begin
            nfail++; $display("FAIL first_step_all: got %h want %h", {body, length, goodColl, badColl, dead, snake}, exp_all());
        end
    endtask

    task automatic test_apple_growth();
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h87, 8'h00);
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 8'h87, 8'h00);
        nvec++;
        if ({goodColl, length, body[3], body[4], body[49]} !== {1'b1, 6'd4, 8'h57, 8'h57, 8'h57}) begin
            nfail++; $display("FAIL apple_grow: got g%b len %0d %h %h %h want g1 len 4 57 57 57",
                              goodColl, length, body[3], body[4], body[49]);
        end
        cyc(1'b0, 1'b0, 1'b0, 2'd3, 8'h87, 8'h00);
        nvec++;
        if (goodColl !== 1'b0) begin
            nfail++; $display("FAIL apple_pulse_width: got %b want 0", goodColl);
        end
    endtask

    task automatic test_reversal();
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h00);
        move(2'd2, 8'h00);
        nvec++;
        if (body[0] !== 8'h87) begin
            nfail++; $display("FAIL reverse_discard: got %h want 87", body[0]);
        end
        cyc(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        move(2'd3, 8'h00);
        nvec++;
        if (body[0] !== 8'h97) begin
            nfail++; $display("FAIL last_request_wins: got %h want 97", body[0]);
        end
        move(2'd0, 8'h00);
        nvec++;
        if (body[0] !== 8'h96) begin
            nfail++; $display("FAIL turn_up: got %h want 96", body[0]);
        end
    endtask

    task automatic test_wall();
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00);
        nvec++;
        if ({body[0], badColl, dead} !== {8'hF7, 1'b0, 1'b0}) begin
            nfail++; $display("FAIL wall_edge_reached: got %h b%b d%b want F7 b0 d0", body[0], badColl, dead);
        end
        cyc(1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h00);
        nvec++;
        if ({body[0], length, badColl, dead, goodColl} !== {8'hF7, 6'd3, 1'b1, 1'b1, 1'b0}) begin
            nfail++; $display("FAIL wall_hit: got %h len %0d b%b d%b g%b want F7 len 3 b1 d1 g0",
                              body[0], length, badColl, dead, goodColl);
        end
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b1, 2'd1, 8'hF8, 8'h00);
        nvec++;
        if ({body, length, goodColl, badColl, dead, snake} !== exp_all()) begin
            nfail++; $display("FAIL dead_frozen: got %h want %h", {body, length, goodColl, badColl, dead, snake}, exp_all());
        end
    endtask

    task automatic test_self();
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h00);
        move(2'd3, 8'h87);
        for (int r = 0; r < 2; r++) begin
            move(2'd0, 8'h00); move(2'd2, 8'h00); move(2'd1, 8'h00); move(2'd3, 8'h00);
        end
        nvec++;
        if ({dead, length, body[0], body[3]} !== {1'b0, 6'd4, 8'h87, 8'h86}) begin
            nfail++; $display("FAIL tail_chase: got d%b len %0d %h %h want d0 len 4 87 86",
                              dead, length, body[0], body[3]);
        end
        move(2'd0, 8'h86);
        nvec++;
        if ({badColl, goodColl, dead, length} !== {1'b1, 1'b0, 1'b1, 6'd4}) begin
            nfail++; $display("FAIL tail_chase_grow: got b%b g%b d%b len %0d want b1 g0 d1 len 4",
                              badColl, goodColl, dead, length);
        end
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h00);
        move(2'd3, 8'h87);
        move(2'd3, 8'h97);
        move(2'd0, 8'h00);
        move(2'd2, 8'h00);
        move(2'd1, 8'h00);
        nvec++;
        if ({badColl, dead, length, body[0]} !== {1'b1, 1'b1, 6'd5, 8'h86}) begin
            nfail++; $display("FAIL self_body3: got b%b d%b len %0d %h want b1 d1 len 5 86",
                              badColl, dead, length, body[0]);
        end
    endtask

    task automatic test_saturation_pixel();
        logic [1:0] path[$];
        logic [7:0] nh, hd;
        for (int i = 0; i < 8; i++)  path.push_back(2'd3);
        path.push_back(2'd1);
        for (int i = 0; i < 15; i++) path.push_back(2'd2);
        path.push_back(2'd1);
        for (int i = 0; i < 15; i++) path.push_back(2'd3);
        path.push_back(2'd1);
        for (int i = 0; i < 7; i++)  path.push_back(2'd2);
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 2'd3, 8'h00, 8'h00);
        for (int i = 0; i < path.size(); i++) begin
            nh = next_cell(mq[0], path[i]);
            move(path[i], nh);
        end
        nvec++;
        if ({goodColl, length, dead} !== {1'b1, 6'd50, 1'b0}) begin
            nfail++; $display("FAIL saturation: got g%b len %0d d%b want g1 len 50 d0", goodColl, length, dead);
        end
        nvec++;
        if ({body, length, goodColl, badColl, dead, snake} !== exp_all()) begin
            nfail++; $display("FAIL saturation_all: got %h want %h", {body, length, goodColl, badColl, dead, snake}, exp_all());
        end
        hd = mq[0];
        cyc(1'b0, 1'b0, 1'b0, 2'd2, 8'h00, hd);
        nvec++;
        if (snake !== 1'b1) begin
            nfail++; $display("FAIL pixel_head: got %b want 1", snake);
        end
        cyc(1'b0, 1'b0, 1'b0, 2'd2, 8'h00, 8'h00);
        nvec++;
        if (snake !== 1'b0) begin
            nfail++; $display("FAIL pixel_empty: got %b want 0", snake);
        end
    endtask

    task automatic test_random();
        logic       r, st, tk;
        logic [1:0] d;
        logic [7:0] ap, q;
        cyc(1'b1, 1'b0, 1'b0, 2'd3, 8'h00, 8'h00);
        for (int n = 0; n < 1500; n++) begin
            r  = ($urandom_range(79) == 0);
            st = ($urandom_range(3) == 0);
            tk = ($urandom_range(2) == 0);
            d  = 2'($urandom_range(3));
            ap = ($urandom_range(3) == 0) ? next_cell(mq[0], m_lat) : 8'($urandom);
            q  = ($urandom_range(1) == 0) ? mq[$urandom_range(mq.size() - 1)] : 8'($urandom);
            if (m_state == 2 && $urandom_range(7) == 0) r = 1'b1;
            cyc(r, st, tk, d, ap, q);
            nvec++;
            if ({body, length, goodColl, badColl, dead, snake} !== exp_all()) begin
                nfail++; $display("FAIL random_cycle_%0d: got %h want %h", n,
                                  {body, length, goodColl, badColl, dead, snake}, exp_all());
            end
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; dir = 2'd3; apple_cord = 8'h00; x = 4'd0; y = 4'd0;
        model_reset();
        test_reset();
        test_start_move();
        test_apple_growth();
        test_reversal();
        test_wall();
        test_self();
        test_saturation_pixel();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
